alarm_sequencer: RTL and testbench

ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

---
 rtl/alarm_pkg.sv | 33 +++
 rtl/alarm_timer.sv | 47 ++++
 rtl/alarm_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alarm_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm sequencer: state encoding, arming-mode type,
// reset mode value and a zone helper used by the next-state logic.
// -----------------------------------------------------------------------------
package alarm_pkg;

  // Moore state encoding; codes 6 and 7 are unused and recover to ST_DISARMED.
  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_ALARM    = 3'd4,
    ST_TRIPPED  = 3'd5
  } state_e;

  // Arming mode latched when an arm request is accepted.
  typedef enum logic {
    MODE_AWAY = 1'b0,
    MODE_STAY = 1'b1
  } mode_e;

  localparam mode_e MODE_RESET = MODE_AWAY;

  // Both modes supervise every door and window zone; they differ only in
  // whether an open door gets an entry delay.
  function automatic logic zones_open(input logic [1:0] doors,
                                      input logic [2:0] windows);
    return (|doors) | (|windows);
  endfunction

endpackage

// File: rtl/alarm_timer.sv
// -----------------------------------------------------------------------------
// alarm_timer
// Loadable down counter. Loading N-1 gives a dwell of exactly N cycles until
// done, which is asserted while the count is zero. The counter holds at zero.
//
// Ports:
//   clk      in  system clock, rising edge
//   rst_n    in  asynchronous active-low reset (count -> 0)
//   load     in  load load_val on the next edge
//   load_val in  value to load (N-1 for an N-cycle dwell)
//   done     out count is zero
// -----------------------------------------------------------------------------
module alarm_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/alarm_sequencer.sv
// -----------------------------------------------------------------------------
// alarm_sequencer
// Intrusion alarm sequencer: arm with exit delay, away/stay supervision,
// entry delay (away mode only), timed siren and tripped hold-off.
//
// Ports:
//   clk       in  system clock, rising edge
//   rst_n     in  asynchronous active-low reset
//   arm       in  one-cycle arm request (accepted only while disarmed)
//   stay      in  mode sampled with an accepted arm (1 = stay, 0 = away)
//   disarm    in  one-cycle disarm request, highest priority
//   doors     in  [1:0] door zones, 1 = open
//   windows   in  [2:0] window zones, 1 = open
//   secure    out premises secure (DISARMED/EXIT/ARMED)
//   alarm     out siren drive (ALARM only)
//   armed     out any state other than DISARMED
//   arm_fault out one-cycle pulse: arm refused because a window is open
//   state     out [2:0] current state encoding
// -----------------------------------------------------------------------------
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int unsigned EXIT_CYCLES  = 16,
  parameter int unsigned ENTRY_CYCLES = 8,
  parameter int unsigned SIREN_CYCLES = 32,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm,
  input  logic       stay,
  input  logic       disarm,
  input  logic [1:0] doors,
  input  logic [2:0] windows,
  output logic       secure,
  output logic       alarm,
  output logic       armed,
  output logic       arm_fault,
  output logic [2:0] state
);

  // Timer is loaded with N-1 so that it reaches zero in the N-th cycle.
  localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_CYCLES - 1);
  localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_CYCLES - 1);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic             arm_fault_q, arm_fault_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;
  logic             any_open;
  logic             win_open;

  assign win_open = |windows;
  assign any_open = zones_open(doors, windows);

  alarm_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .load_val(tmr_val),
    .done    (tmr_done)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    arm_fault_d = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    if (disarm) begin
      state_d = ST_DISARMED;
    end else begin
      unique case (state_q)
        ST_DISARMED: begin
          if (arm) begin
            if (!win_open) begin
              state_d  = ST_EXIT;
              mode_d   = stay ? MODE_STAY : MODE_AWAY;
              tmr_load = 1'b1;
              tmr_val  = EXIT_LOAD;
            end else begin
              arm_fault_d = 1'b1;
            end
          end
        end

        // Doors are deliberately ignored while the occupant walks out.
        ST_EXIT: begin
          if (win_open) begin
            state_d  = ST_ALARM;
            tmr_load = 1'b1;
            tmr_val  = SIREN_LOAD;
          end else if (tmr_done) begin
            state_d = ST_ARMED;
          end
        end

        ST_ARMED: begin
          if (mode_q == MODE_STAY) begin
            if (any_open) begin
              state_d  = ST_ALARM;
              tmr_load = 1'b1;
              tmr_val  = SIREN_LOAD;
            end
          end else if (win_open) begin
            state_d  = ST_ALARM;
            tmr_load = 1'b1;
            tmr_val  = SIREN_LOAD;
          end else if (|doors) begin
            state_d  = ST_ENTRY;
            tmr_load = 1'b1;
            tmr_val  = ENTRY_LOAD;
          end
        end

        // Closing the door again does not cancel the entry countdown.
        ST_ENTRY: begin
          if (win_open || tmr_done) begin
            state_d  = ST_ALARM;
            tmr_load = 1'b1;
            tmr_val  = SIREN_LOAD;
          end
        end

        ST_ALARM: begin
          if (tmr_done) begin
            state_d = any_open ? ST_TRIPPED : ST_ARMED;
          end
        end

        ST_TRIPPED: begin
          if (!any_open) begin
            state_d = ST_ARMED;
          end
        end

        default: begin
          state_d = ST_DISARMED;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_DISARMED;
      mode_q      <= MODE_RESET;
      arm_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      arm_fault_q <= arm_fault_d;
    end
  end

  // Moore outputs decoded from the state register only.
  assign state     = state_q;
  assign secure    = (state_q == ST_DISARMED) || (state_q == ST_EXIT) ||
                     (state_q == ST_ARMED);
  assign alarm     = (state_q == ST_ALARM);
  assign armed     = (state_q != ST_DISARMED);
  assign arm_fault = arm_fault_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alarm_sequencer
// Directed scenarios with a scoreboard: each stimulus step pushes the expected
// state and arm_fault, and the entry is popped and compared after the edge.
// -----------------------------------------------------------------------------
module tb_alarm_sequencer;

  localparam int unsigned EXIT_C  = 4;
  localparam int unsigned ENTRY_C = 3;
  localparam int unsigned SIREN_C = 5;

  localparam logic [2:0] S_DIS  = 3'd0;
  localparam logic [2:0] S_EXIT = 3'd1;
  localparam logic [2:0] S_ARM  = 3'd2;
  localparam logic [2:0] S_ENT  = 3'd3;
  localparam logic [2:0] S_ALM  = 3'd4;
  localparam logic [2:0] S_TRIP = 3'd5;

  logic       clk;
  logic       rst_n;
  logic       arm;
  logic       stay;
  logic       disarm;
  logic [1:0] doors;
  logic [2:0] windows;
  logic       secure;
  logic       alarm;
  logic       armed;
  logic       arm_fault;
  logic [2:0] state;

  typedef struct packed {
    logic [2:0] st;
    logic       fault;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_pass;

  alarm_sequencer #(
    .EXIT_CYCLES (EXIT_C),
    .ENTRY_CYCLES(ENTRY_C),
    .SIREN_CYCLES(SIREN_C),
    .CNT_W       (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .arm      (arm),
    .stay     (stay),
    .disarm   (disarm),
    .doors    (doors),
    .windows  (windows),
    .secure   (secure),
    .alarm    (alarm),
    .armed    (armed),
    .arm_fault(arm_fault),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Output decode derived from the expected state.
  task automatic check_outputs(input string tag, input logic [2:0] st,
                               input logic fault);
    check({tag, ".state"},  32'(state), 32'(st));
    check({tag, ".secure"}, 32'(secure),
          32'(st == S_DIS || st == S_EXIT || st == S_ARM));
    check({tag, ".alarm"},  32'(alarm), 32'(st == S_ALM));
    check({tag, ".armed"},  32'(armed), 32'(st != S_DIS));
    check({tag, ".fault"},  32'(arm_fault), 32'(fault));
  endtask

  task automatic step(input string tag, input logic a, input logic s,
                      input logic d, input logic [1:0] dr,
                      input logic [2:0] w, input logic [2:0] exp_st,
                      input logic exp_f);
    exp_t e;
    @(negedge clk);
    arm     = a;
    stay    = s;
    disarm  = d;
    doors   = dr;
    windows = w;
    e.st    = exp_st;
    e.fault = exp_f;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_outputs(tag, e.st, e.fault);
  endtask

  task automatic idle(input string tag, input int n, input logic [2:0] exp_st);
    for (int i = 0; i < n; i++) begin
      step(tag, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, exp_st, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    arm      = 1'b0;
    stay     = 1'b0;
    disarm   = 1'b0;
    doors    = 2'b00;
    windows  = 3'b000;
    #12;
    check_outputs("reset", S_DIS, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Arm refused with a window open: one-cycle fault pulse.
    step("fault_arm",  1, 0, 0, 2'b00, 3'b100, S_DIS, 1'b1);
    step("fault_gone", 0, 0, 0, 2'b00, 3'b100, S_DIS, 1'b0);

    // Away arm: EXIT lasts 4 cycles, doors ignored in EXIT.
    step("arm_away",   1, 0, 0, 2'b00, 3'b000, S_EXIT, 1'b0);
    step("exit_door",  0, 0, 0, 2'b01, 3'b000, S_EXIT, 1'b0);
    idle("exit_hold", EXIT_C - 2, S_EXIT);
    idle("exit_done", 1, S_ARM);
    step("arm_ignored", 1, 1, 0, 2'b00, 3'b000, S_ARM, 1'b0);

    // Door trip: ENTRY 3 cycles, ALARM 5 cycles, back to ARMED.
    step("entry_in",   0, 0, 0, 2'b01, 3'b000, S_ENT, 1'b0);
    idle("entry_hold", ENTRY_C - 1, S_ENT);
    idle("alarm_in",   1, S_ALM);
    idle("alarm_hold", SIREN_C - 1, S_ALM);
    idle("alarm_rearm", 1, S_ARM);

    // Disarm in the 2nd ENTRY cycle.
    step("entry2_in",  0, 0, 0, 2'b01, 3'b000, S_ENT, 1'b0);
    idle("entry2_c2",  1, S_ENT);
    step("entry2_dis", 0, 0, 1, 2'b00, 3'b000, S_DIS, 1'b0);

    // Away: window beats door in the same cycle; window held past siren -> TRIPPED.
    step("arm_away2",  1, 0, 0, 2'b00, 3'b000, S_EXIT, 1'b0);
    idle("exit2_hold", EXIT_C - 1, S_EXIT);
    idle("exit2_done", 1, S_ARM);
    step("win_prio",   0, 0, 0, 2'b11, 3'b001, S_ALM, 1'b0);
    idle("siren2",     SIREN_C - 1, S_ALM);
    step("tripped",    0, 0, 0, 2'b00, 3'b010, S_TRIP, 1'b0);
    step("trip_hold",  0, 0, 0, 2'b00, 3'b010, S_TRIP, 1'b0);
    step("trip_clear", 0, 0, 0, 2'b00, 3'b000, S_ARM, 1'b0);

    // Window during ENTRY cuts the delay short.
    step("entry3_in",  0, 0, 0, 2'b01, 3'b000, S_ENT, 1'b0);
    step("entry3_win", 0, 0, 0, 2'b00, 3'b001, S_ALM, 1'b0);
    step("dis3",       0, 0, 1, 2'b00, 3'b000, S_DIS, 1'b0);

    // Window during EXIT goes straight to ALARM.
    step("arm_exitwin", 1, 0, 0, 2'b00, 3'b000, S_EXIT, 1'b0);
    step("exit_win",    0, 0, 0, 2'b00, 3'b100, S_ALM, 1'b0);
    step("dis4",        0, 0, 1, 2'b00, 3'b000, S_DIS, 1'b0);

    // Stay mode: door goes straight to ALARM, held open -> TRIPPED, close -> ARMED.
    step("arm_stay",   1, 1, 0, 2'b00, 3'b000, S_EXIT, 1'b0);
    idle("exit5_hold", EXIT_C - 1, S_EXIT);
    idle("exit5_done", 1, S_ARM);
    step("stay_door",  0, 0, 0, 2'b10, 3'b000, S_ALM, 1'b0);
    for (int i = 0; i < int'(SIREN_C) - 1; i++) begin
      step("stay_siren", 0, 0, 0, 2'b10, 3'b000, S_ALM, 1'b0);
    end
    step("stay_trip",  0, 0, 0, 2'b10, 3'b000, S_TRIP, 1'b0);
    step("stay_hold",  0, 0, 0, 2'b10, 3'b000, S_TRIP, 1'b0);
    step("stay_close", 0, 0, 0, 2'b00, 3'b000, S_ARM, 1'b0);
    step("dis5",       0, 0, 1, 2'b00, 3'b000, S_DIS, 1'b0);

    // Disarm wins over a same-cycle arm, including a would-be fault.
    step("arm_dis",     1, 0, 1, 2'b00, 3'b000, S_DIS, 1'b0);
    step("arm_dis_win", 1, 0, 1, 2'b00, 3'b001, S_DIS, 1'b0);

    // Reset during ALARM clears outputs asynchronously; next edge is normal.
    step("arm_stay6",  1, 1, 0, 2'b00, 3'b000, S_EXIT, 1'b0);
    idle("exit6_hold", EXIT_C - 1, S_EXIT);
    idle("exit6_done", 1, S_ARM);
    step("stay6_door", 0, 0, 0, 2'b01, 3'b000, S_ALM, 1'b0);
    idle("alarm6",     1, S_ALM);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs("rst_async", S_DIS, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle("post_rst", 2, S_DIS);
    step("post_rst_arm", 1, 0, 0, 2'b00, 3'b000, S_EXIT, 1'b0);
    step("post_rst_dis", 0, 0, 1, 2'b00, 3'b000, S_DIS, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
